// File: rtl/gf180mcu_osu_sc_9t_clkdiv_pkg.sv
// ---------------------------------------------------------------------------
// gf180mcu_osu_sc_9t_clkdiv_pkg
// Shared types and helpers for the programmable clock divider.
//   state_e      : divider FSM state (IDLE / HIGH / LOW)
//   MIN_DIV      : smallest ratio the divider can produce
//   clamp_div    : lifts any requested ratio below MIN_DIV up to MIN_DIV
//   hi_len/lo_len: high/low phase lengths of a period of ratio n
// ---------------------------------------------------------------------------
package gf180mcu_osu_sc_9t_clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned clamp_div(input int unsigned n);
    return (n < MIN_DIV) ? MIN_DIV : n;
  endfunction

  // Odd ratios put their extra cycle in the high phase.
  function automatic int unsigned hi_len(input int unsigned n);
    return (n >> 1) + (n & 32'd1);
  endfunction

  function automatic int unsigned lo_len(input int unsigned n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_9t_clkdiv_phase_cnt.sv
// ---------------------------------------------------------------------------
// gf180mcu_osu_sc_9t_clkdiv_phase_cnt
// Loadable down-counter timing one CLKOUT phase.
//   clk    : source clock
//   rst    : synchronous active-high reset (count -> 0)
//   ld     : load ld_val this cycle (has priority over counting)
//   ld_val : remaining cycles of the phase minus one
//   zero   : count has reached zero (last cycle of the phase)
// The count holds at zero rather than wrapping, so an idle divider keeps
// a quiet, well-defined counter.
// ---------------------------------------------------------------------------
module gf180mcu_osu_sc_9t_clkdiv_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (ld) begin
      cnt_q <= ld_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gf180mcu_osu_sc_9t_clkdiv_prog.sv
// ---------------------------------------------------------------------------
// gf180mcu_osu_sc_9t_clkdiv_prog
// Programmable glitch-free clock divider feeding the 9T clock-buffer tree.
//   CLK     : source clock, all state on its rising edge
//   RST     : synchronous active-high reset
//   EN      : run request, sampled in IDLE and at each period boundary
//   DIV_LD  : one-cycle request to load DIV_VAL
//   DIV_VAL : requested ratio N (values below 2 are taken as 2)
//   DIV_ACK : one-cycle pulse, the pending ratio took effect
//   CLKOUT  : divided clock, straight from a flop
//   ACTIVE  : a period is running (state HIGH or LOW)
//   TICK    : one-cycle pulse on each CLKOUT rising cycle
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | stopped, CLKOUT parked low; every edge is a period boundary
// HIGH  | high phase of a running period, CLKOUT=1
// LOW   | low phase of a running period, CLKOUT=0; its last cycle is
//       | the period boundary where ratio changes and EN are taken
// ---------------------------------------------------------------------------
module gf180mcu_osu_sc_9t_clkdiv_prog
  import gf180mcu_osu_sc_9t_clkdiv_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIV_LD,
  input  logic [DIV_W-1:0] DIV_VAL,
  output logic             DIV_ACK,
  output logic             CLKOUT,
  output logic             ACTIVE,
  output logic             TICK
);

  state_e           state_q;
  state_e           state_d;

  logic [DIV_W-1:0] cur_div_q;
  logic [DIV_W-1:0] pend_div_q;
  logic             pend_vld_q;

  logic [DIV_W-1:0] ld_div;
  logic [DIV_W-1:0] eff_div;
  logic             boundary;
  logic             apply_div;

  logic             cnt_ld;
  logic [DIV_W-1:0] cnt_ld_val;
  logic             cnt_zero;

  logic             clkout_d;
  logic             tick_d;
  logic             ack_d;

  assign ld_div = DIV_W'(clamp_div(32'(DIV_VAL)));

  // A load arriving on the boundary edge itself wins over any older
  // pending value, so the starting period already uses it.
  assign boundary  = (state_q == IDLE) || ((state_q == LOW) && cnt_zero);
  assign apply_div = boundary && (DIV_LD || pend_vld_q);
  assign eff_div   = DIV_LD     ? ld_div     :
                     pend_vld_q ? pend_div_q : cur_div_q;

  gf180mcu_osu_sc_9t_clkdiv_phase_cnt #(
    .W (DIV_W)
  ) u_phase_cnt (
    .clk    (CLK),
    .rst    (RST),
    .ld     (cnt_ld),
    .ld_val (cnt_ld_val),
    .zero   (cnt_zero)
  );

  // state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (EN) state_d = HIGH;
      end
      HIGH: begin
        if (cnt_zero) state_d = LOW;
      end
      LOW: begin
        if (cnt_zero) state_d = EN ? HIGH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // output / counter-load logic; outputs are registered below
  always_comb begin
    clkout_d   = CLKOUT;
    tick_d     = 1'b0;
    ack_d      = apply_div;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    if ((state_d == HIGH) && (state_q != HIGH)) begin
      clkout_d   = 1'b1;
      tick_d     = 1'b1;
      cnt_ld     = 1'b1;
      cnt_ld_val = DIV_W'(hi_len(32'(eff_div)) - 32'd1);
    end else if ((state_d == LOW) && (state_q == HIGH)) begin
      clkout_d   = 1'b0;
      cnt_ld     = 1'b1;
      cnt_ld_val = DIV_W'(lo_len(32'(cur_div_q)) - 32'd1);
    end else if (state_d == IDLE) begin
      clkout_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      CLKOUT     <= 1'b0;
      TICK       <= 1'b0;
      DIV_ACK    <= 1'b0;
      cur_div_q  <= DIV_W'(DEF_DIV);
      pend_div_q <= DIV_W'(DEF_DIV);
      pend_vld_q <= 1'b0;
    end else begin
      CLKOUT  <= clkout_d;
      TICK    <= tick_d;
      DIV_ACK <= ack_d;
      if (apply_div) begin
        cur_div_q  <= eff_div;
        pend_vld_q <= 1'b0;
      end else if (DIV_LD) begin
        pend_div_q <= ld_div;
        pend_vld_q <= 1'b1;
      end
    end
  end

  assign ACTIVE = (state_q != IDLE);

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_clkdiv_prog.sv
// ---------------------------------------------------------------------------
// tb_gf180mcu_osu_sc_9t_clkdiv_prog
// Directed scenarios followed by random traffic, all checked every cycle
// against a period-position reference model.
// ---------------------------------------------------------------------------
module tb_gf180mcu_osu_sc_9t_clkdiv_prog;

  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             EN;
  logic             DIV_LD;
  logic [DIV_W-1:0] DIV_VAL;
  logic             DIV_ACK;
  logic             CLKOUT;
  logic             ACTIVE;
  logic             TICK;

  always #5 CLK = ~CLK;

  gf180mcu_osu_sc_9t_clkdiv_prog #(
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .DIV_LD  (DIV_LD),
    .DIV_VAL (DIV_VAL),
    .DIV_ACK (DIV_ACK),
    .CLKOUT  (CLKOUT),
    .ACTIVE  (ACTIVE),
    .TICK    (TICK)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position within the running period, 0..n-1.
  bit m_run;
  int m_pos;
  int m_n;
  int m_cur;
  int m_pend;
  bit m_pend_v;
  bit e_clk;
  bit e_ack;
  bit e_tick;
  bit en_cur;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Predicts the outputs after the next rising edge for the given inputs.
  task automatic model_step(input bit r, input bit en, input bit ld, input int val);
    int  ldv;
    bit  bnd;
    ldv = (val < 2) ? 2 : val;
    e_ack  = 1'b0;
    e_tick = 1'b0;
    if (r) begin
      m_run    = 1'b0;
      m_pos    = 0;
      m_cur    = DEF_DIV;
      m_pend_v = 1'b0;
    end else begin
      bnd = !m_run || (m_pos == m_n - 1);
      if (bnd) begin
        if (ld) begin
          m_cur = ldv; e_ack = 1'b1; m_pend_v = 1'b0;
        end else if (m_pend_v) begin
          m_cur = m_pend; e_ack = 1'b1; m_pend_v = 1'b0;
        end
        if (en) begin
          m_run = 1'b1; m_n = m_cur; m_pos = 0; e_tick = 1'b1;
        end else begin
          m_run = 1'b0;
        end
      end else begin
        m_pos++;
        if (ld) begin
          m_pend = ldv; m_pend_v = 1'b1;
        end
      end
    end
    e_clk = m_run && (m_pos < (m_n + 1) / 2);
  endtask

  task automatic step(input bit r, input bit en, input bit ld, input int val);
    @(negedge CLK);
    check_val("clkout",  CLKOUT,  e_clk);
    check_val("active",  ACTIVE,  m_run);
    check_val("tick",    TICK,    e_tick);
    check_val("div_ack", DIV_ACK, e_ack);
    RST     = r;
    EN      = en;
    DIV_LD  = ld;
    DIV_VAL = val[DIV_W-1:0];
    model_step(r, en, ld, val);
  endtask

  initial begin
    bit reached;
    RST = 1'b1; EN = 1'b0; DIV_LD = 1'b0; DIV_VAL = '0;
    model_step(1'b1, 1'b0, 1'b0, 0);
    repeat (2) @(posedge CLK);

    // reset state, then run at the default ratio
    repeat (3) step(1'b1, 1'b0, 1'b0, 0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 0);
    repeat (12) step(1'b0, 1'b1, 1'b0, 0);

    // load 5 during a high phase
    reached = 1'b0;
    for (int k = 0; k < 10 && !reached; k++) begin
      if (m_run && m_pos == 0) reached = 1'b1;
      else step(1'b0, 1'b1, 1'b0, 0);
    end
    check_val("reach_high_n4", reached, 1'b1);
    step(1'b0, 1'b1, 1'b1, 5);
    repeat (16) step(1'b0, 1'b1, 1'b0, 0);

    // clamped ratios
    step(1'b0, 1'b1, 1'b1, 0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 1);
    repeat (10) step(1'b0, 1'b1, 1'b0, 0);

    // two loads inside one period: 6 then 3
    step(1'b0, 1'b1, 1'b1, 8);
    repeat (4) step(1'b0, 1'b1, 1'b0, 0);
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      if (m_run && m_pos == 0 && m_n == 8) reached = 1'b1;
      else step(1'b0, 1'b1, 1'b0, 0);
    end
    check_val("reach_n8", reached, 1'b1);
    step(1'b0, 1'b1, 1'b1, 6);
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 3);
    repeat (16) step(1'b0, 1'b1, 1'b0, 0);

    // EN dropped in the second high cycle at N=6
    step(1'b0, 1'b1, 1'b1, 6);
    reached = 1'b0;
    for (int k = 0; k < 30 && !reached; k++) begin
      if (m_run && m_pos == 1 && m_n == 6) reached = 1'b1;
      else step(1'b0, 1'b1, 1'b0, 0);
    end
    check_val("reach_n6_pos1", reached, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b0, 0);

    // reset during a high phase with a load pending
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      if (m_run && m_pos == 0) reached = 1'b1;
      else step(1'b0, 1'b1, 1'b0, 0);
    end
    check_val("reach_high_rst", reached, 1'b1);
    step(1'b0, 1'b1, 1'b1, 7);
    step(1'b1, 1'b1, 1'b0, 0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 0);

    // random traffic
    en_cur = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit ld;
      int val;
      r  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) en_cur = !en_cur;
      ld = ($urandom_range(0, 9) == 0);
      val = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 9));
      step(r, en_cur, ld, val);
    end

    // final compare of the last predicted edge
    step(1'b0, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gf180mcu_osu_sc_9t_clkdiv_prog.md
Name: gf180mcu_osu_sc_9T_clkdiv_prog

Overview:
- Programmable, glitch-free clock divider that sits directly upstream of the 9T clock-buffer cells in the clock tree.
- Generates a registered divided clock, CLKOUT, from CLK; CTS buffers then distribute CLKOUT.
- Divide ratio changes only at period boundaries, through a load/acknowledge handshake.
- Stopping is clean: the current period always finishes before CLKOUT parks low.

Parameters:
- DIV_W, 8, width of the divide-ratio field.
- DEF_DIV, 4, divide ratio loaded on reset; must be >= 2.

Ports:
- CLK  input  1  source clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  run request; sampled at each period boundary and in IDLE.
- DIV_LD  input  1  single-cycle request to load DIV_VAL.
- DIV_VAL  input  DIV_W  requested divide ratio N.
- DIV_ACK  output  1  one-cycle pulse: the pending ratio took effect this cycle.
- CLKOUT  output  1  divided clock, driven straight from a flop.
- ACTIVE  output  1  high while state is HIGH or LOW.
- TICK  output  1  one-cycle pulse on each CLKOUT rising cycle.

Behaviour:
- Reset (RST=1 at an edge):
  - state=IDLE; CLKOUT=0, DIV_ACK=0, ACTIVE=0, TICK=0.
  - cur_div=DEF_DIV; pending flag cleared; counter=0.
  - Reset overrides everything, including mid-period; CLKOUT is 0 on the next cycle.
- Ratio clamp: any DIV_VAL < 2 is captured as 2. No upper clamp; max N = 2^DIV_W-1.
- Phase lengths:
  - high phase H = ceil(N/2) cycles; low phase L = floor(N/2) cycles.
  - Odd N therefore has its extra cycle in the high phase.
- Load capture:
  - DIV_LD=1 captures clamp(DIV_VAL) into pend_div and sets pend_vld.
  - A second DIV_LD while pend_vld=1 overwrites pend_div; only one ACK follows.
- State IDLE:
  - If pend_vld=1: apply it (cur_div<=pend_div, clear pend_vld, DIV_ACK=1 next cycle), independent of EN.
  - If EN=1: next edge goes to HIGH with CLKOUT=1, TICK=1, cnt=H-1, using the ratio applied on that same edge if any.
- State HIGH:
  - cnt decrements each cycle.
  - At cnt==0: go to LOW, CLKOUT=0, cnt=L-1.
- State LOW:
  - cnt decrements each cycle.
  - At cnt==0 (period boundary): apply pend_vld if set, with DIV_ACK on the next cycle.
  - Then, if EN=1: go to HIGH (CLKOUT=1, TICK=1, new H); otherwise go to IDLE.
- EN deassertion: takes effect only at the period boundary. No runt pulses; CLKOUT never changes mid-phase.
- Simultaneous DIV_LD and boundary on the same edge: the new DIV_VAL is used directly for the starting period and ACKed. It does not wait a period.
- Timing relationships:
  - DIV_ACK coincides with the first CLKOUT=1 cycle of the new ratio when running.
  - ACTIVE is 1 exactly when CLKOUT belongs to a running period.

Decomposition:
- Package gf180mcu_osu_sc_9T_clkdiv_pkg holds:
  - state enum {IDLE, HIGH, LOW};
  - MIN_DIV=2;
  - clamp function and half-period functions (ceil/floor of N/2).
- Sub-module gf180mcu_osu_sc_9T_clkdiv_phase_cnt: loadable down-counter with a zero flag, instantiated once.

Test Plan:
- Reset: assert RST during an active HIGH phase -> next cycle CLKOUT=0, ACTIVE=0, pending load dropped (no DIV_ACK afterwards).
- EN=1 from reset, DEF_DIV=4 -> CLKOUT pattern 1,1,0,0 repeating; first 1 one cycle after EN sampled; TICK on each first 1.
- Running N=4, pulse DIV_LD with DIV_VAL=5 mid high phase -> current 1100 period completes, then 1,1,1,0,0 repeating; DIV_ACK coincides with the first 1 of the 5-period.
- DIV_VAL=0 and DIV_VAL=1 loads -> both clamp to 2; CLKOUT toggles 1,0,1,0.
- Two DIV_LD pulses (6 then 3) within one period -> single DIV_ACK; ratio 3 applied (pattern 1,1,0).
- EN dropped on the 2nd cycle of HIGH, N=6 -> CLKOUT finishes 1,1,1,0,0,0 then stays 0; ACTIVE falls at the boundary.
